// File: rtl/ctrl_pkg.sv
// Shared encodings for the decode-to-writeback control pipeline.
package ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_JAL  = 2'b01;
  localparam logic [1:0] J_JALR = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_TGT = 2'b01;
  localparam logic [1:0] PC_ALU = 2'b10;

  // Field widths of the E-stage bundle excluding rd
  localparam int unsigned E_CTRL_W = 14;
  localparam int unsigned M_CTRL_W = 5;
  localparam int unsigned W_CTRL_W = 4;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Pipeline stage register: clear (bubble) has priority over enable (not stalled).
module ctrl_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded control through E/M/W, resolves branches in E, counts retirements.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validD,
  input  logic             regWriteD,
  input  logic             memWriteD,
  input  logic             ALUSrcD,
  input  logic             luiD,
  input  logic [1:0]       resultSrcD,
  input  logic [1:0]       jumpD,
  input  logic [1:0]       ALUOpD,
  input  logic [2:0]       branchD,
  input  logic [RD_W-1:0]  rdD,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             zeroE,
  input  logic             ltE,
  output logic             ALUSrcE,
  output logic             luiE,
  output logic             memWriteE,
  output logic             regWriteE,
  output logic [1:0]       ALUOpE,
  output logic [1:0]       resultSrcE,
  output logic [RD_W-1:0]  rdE,
  output logic [1:0]       pcSrcE,
  output logic             takenE,
  output logic             regWriteM,
  output logic             memWriteM,
  output logic [1:0]       resultSrcM,
  output logic [RD_W-1:0]  rdM,
  output logic             regWriteW,
  output logic [1:0]       resultSrcW,
  output logic [RD_W-1:0]  rdW,
  output logic [CNT_W-1:0] retiredCnt
);

  localparam int unsigned EW = E_CTRL_W + RD_W;
  localparam int unsigned MW = M_CTRL_W + RD_W;
  localparam int unsigned WW = W_CTRL_W + RD_W;

  logic [EW-1:0] w_d_bus, w_e_q;
  logic [MW-1:0] w_m_d, w_m_q;
  logic [WW-1:0] w_w_d, w_w_q;
  logic          w_e_valid, w_m_valid, w_w_valid;
  logic [1:0]    w_e_jump;
  logic [2:0]    w_e_branch;
  logic          w_br_taken;
  logic [CNT_W-1:0] r_cnt;

  // Invalid D slots enter as all-zero so no stage ever carries stray controls
  assign w_d_bus = validD ? {1'b1, regWriteD, memWriteD, ALUSrcD, luiD, resultSrcD,
                             jumpD, ALUOpD, branchD, rdD} : '0;

  ctrl_stage_reg #(.W(EW)) u_stage_e (
    .clk(clk), .rst_n(rst_n), .en(~stallE), .clr(flushE), .d(w_d_bus), .q(w_e_q)
  );

  assign {w_e_valid, regWriteE, memWriteE, ALUSrcE, luiE, resultSrcE,
          w_e_jump, ALUOpE, w_e_branch, rdE} = w_e_q;

  // A held E instruction must not also advance, so M takes a bubble
  assign w_m_d = {w_e_valid, regWriteE, memWriteE, resultSrcE, rdE};

  ctrl_stage_reg #(.W(MW)) u_stage_m (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(stallE & ~flushE), .d(w_m_d), .q(w_m_q)
  );

  assign {w_m_valid, regWriteM, memWriteM, resultSrcM, rdM} = w_m_q;

  assign w_w_d = {w_m_valid, regWriteM, resultSrcM, rdM};

  ctrl_stage_reg #(.W(WW)) u_stage_w (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .d(w_w_d), .q(w_w_q)
  );

  assign {w_w_valid, regWriteW, resultSrcW, rdW} = w_w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_w_valid) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign retiredCnt = r_cnt;

  // Branch direction from the ALU flags
  always_comb begin
    w_br_taken = 1'b0;
    case (w_e_branch)
      BR_BEQ:  w_br_taken = zeroE;
      BR_BNE:  w_br_taken = ~zeroE;
      BR_BLT:  w_br_taken = ltE;
      BR_BGE:  w_br_taken = ~ltE;
      default: w_br_taken = 1'b0;
    endcase
  end

  // Jumps take precedence over branches; an invalid E never redirects
  always_comb begin
    pcSrcE = PC_SEQ;
    if (w_e_valid) begin
      case (w_e_jump)
        J_JAL:   pcSrcE = PC_TGT;
        J_JALR:  pcSrcE = PC_ALU;
        J_NONE:  pcSrcE = w_br_taken ? PC_TGT : PC_SEQ;
        default: pcSrcE = PC_SEQ;
      endcase
    end
    takenE = (pcSrcE != PC_SEQ);
  end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Consumer end of the decode-stage control bundle in the 5-stage pipelined RISC-V core.
- Registers the decoded control word and destination register through the E, M and W stages.
- Resolves branch and jump direction in E to produce the PC-select and taken signals.
- Exposes per-stage regWrite/rd for the hazard/forwarding unit and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
RD_W, 5, destination register index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
validD  input  1  D stage holds a real instruction
regWriteD  input  1  decoded register write enable
memWriteD  input  1  decoded memory write enable
ALUSrcD  input  1  ALU B-operand select (1 = immediate)
luiD  input  1  LUI instruction
resultSrcD  input  2  00 ALU, 01 mem, 10 PC+4, 11 imm
jumpD  input  2  00 none, 01 JAL, 10 JALR
ALUOpD  input  2  ALU operation class
branchD  input  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE
rdD  input  RD_W  destination register
stallE  input  1  hold E register
flushE  input  1  turn E into a bubble
zeroE  input  1  ALU result == 0
ltE  input  1  signed A < B from ALU
ALUSrcE, luiE, memWriteE, regWriteE  output  1 each  E-stage controls
ALUOpE  output  2  E-stage ALU class
resultSrcE  output  2  E-stage result select (hazard load-use check)
rdE  output  RD_W  E-stage destination
pcSrcE  output  2  00 PC+4, 01 PC+imm, 10 ALU result (JALR)
takenE  output  1  control transfer taken in E
regWriteM, memWriteM  output  1 each  M-stage controls
resultSrcM  output  2  M-stage result select
rdM  output  RD_W  M-stage destination
regWriteW  output  1  W-stage register write enable
resultSrcW  output  2  W-stage result select
rdW  output  RD_W  W-stage destination
retiredCnt  output  CNT_W  count of valid instructions leaving W

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers, valid bits and retiredCnt go to 0; pcSrcE = 00; takenE = 0. Outputs stay 0 until rst_n rises and a valid instruction enters.
- E register update each rising edge, in priority order:
  - flushE: load bubble (valid = 0, all controls 0, rd = 0).
  - else stallE: hold contents.
  - else: load the D bundle with validD.
- flushE wins over stallE when both are asserted.
- M register always loads from E. If stallE is asserted and flushE is not, M loads a bubble so the held E instruction is not duplicated.
- W register always loads from M.
- Latency: D to E 1 cycle, E to M 1 cycle, M to W 1 cycle.
- Outputs of invalid stages are forced to 0; regWrite and memWrite are never asserted for a bubble.
- Branch resolution in E is combinational from E-stage regs, zeroE and ltE:
  - BEQ taken when zeroE; BNE when !zeroE; BLT when ltE; BGE when !ltE.
  - Any other branch code is never taken.
  - JAL gives pcSrcE = 01; JALR gives pcSrcE = 10; a taken branch gives pcSrcE = 01; otherwise pcSrcE = 00.
  - If both jump and branch are nonzero, jump wins.
  - takenE = (pcSrcE != 00). Forced to 0 when E is invalid.
- takenE does not self-flush. The hazard unit drives flushE/flushD from it next cycle.
- retiredCnt increments by 1 on each edge where the W-stage valid bit is 1. It wraps from all-ones to 0 with no flag.
- Reset mid-operation: all in-flight instructions are discarded immediately; no partial retire is counted.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants R/I/S/B/U/J/LW/JALR.
  - Branch codes BR_NONE/BEQ/BNE/BLT/BGE.
  - Jump codes J_NONE/JAL/JALR.
  - Result-select codes RES_ALU/MEM/PC4/IMM.
  - pcSrc codes PC_SEQ/PC_TGT/PC_ALU.
- One sub-module, ctrl_stage_reg: a width-parameterised register with async active-low reset, en (stall), clr (flush, clr over en). Instantiated once per stage.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0, retiredCnt = 0. Release rst_n, issue ADDI (regWriteD = 1, ALUSrcD = 1, rdD = 5) -> regWriteE = 1 after 1 edge, rdM = 5 after 2, regWriteW = 1 after 3, retiredCnt = 1 after 4.
- Branches: BEQ in E with zeroE = 1 -> pcSrcE = 01, takenE = 1; with zeroE = 0 -> 00/0. BGE with ltE = 0 -> 01; BLT with ltE = 0 -> 00.
- Jumps: JAL -> pcSrcE = 01; JALR -> pcSrcE = 10; resultSrcW = 10 three edges after entry.
- Stall/flush: SW held in E with stallE for 2 cycles -> E holds memWriteE = 1, M shows 2 bubbles (memWriteM = 0), then memWriteM = 1 once. flushE and stallE together -> E becomes a bubble.
- Counter wrap: force retiredCnt to all-ones, retire 1 instruction -> 0. Assert rst_n low with 3 instructions in flight -> counter stays 0, no regWriteW pulse.
